// File: rtl/sevenseg_reader_if.sv
// Frame handshake bundle for the seven-segment reader.
// Carries decoded digits and per-digit error flags.
interface sevenseg_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    frame_valid;
  logic                    frame_ready;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_err;

  modport master (
    output frame_valid,
    output digits,
    output digit_err,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  digits,
    input  digit_err,
    output frame_ready
  );
endinterface

// File: rtl/sevenseg_reader.sv
// Samples a multiplexed active-low 7-seg bus and rebuilds
// the per-digit values, handing full frames downstream.
module sevenseg_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [6:0]            seg_n,
  input  logic [NUM_DIGITS-1:0] an_n,
  sevenseg_reader_if.master     frame,
  output logic                  overrun
);

  localparam int ND = NUM_DIGITS;
  localparam int W  = ND + 7;
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  logic [W-1:0]    sync1;
  logic [W-1:0]    sample;
  logic [7:0]      cnt;
  logic [4*ND-1:0] buf_d;
  logic [ND-1:0]   buf_e;
  logic [ND-1:0]   seen;

  logic [ND-1:0] an_lo;
  logic          one_low;
  logic          strobe;
  logic          cap;
  logic [4:0]    dec;
  logic          full;
  logic          hs;
  logic          load;
  logic          drop;

  // {err, value}
  function automatic logic [4:0] decode(
    input logic [6:0] s
  );
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h18:   r = 5'h09;
      7'h7F:   r = 5'h0F;
      default: r = 5'h1E;
    endcase
    return r;
  endfunction

  assign an_lo   = ~sample[W-1:7];
  assign one_low = (an_lo != '0) &&
                   ((an_lo & (an_lo - 1'b1)) == '0);
  // fires on the edge the counter reaches LAST
  assign strobe  = (sync1 == sample) &&
                   (cnt == LAST - 8'd1);
  assign cap     = strobe && one_low;
  assign dec     = decode(sample[6:0]);

  assign full = &seen;
  assign hs   = frame.frame_valid && frame.frame_ready;
  assign load = full && (!frame.frame_valid ||
                         frame.frame_ready);
  assign drop = full && frame.frame_valid &&
                !frame.frame_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1             <= '1;
      sample            <= '1;
      cnt               <= '0;
      buf_d             <= '0;
      buf_e             <= '0;
      seen              <= '0;
      frame.frame_valid <= 1'b0;
      frame.digits      <= '0;
      frame.digit_err   <= '0;
      overrun           <= 1'b0;
    end else begin
      sync1  <= {an_n, seg_n};
      sample <= sync1;

      if (sync1 != sample)
        cnt <= '0;
      else if (cnt != LAST)
        cnt <= cnt + 8'd1;

      if (full)
        seen <= '0;

      if (cap) begin
        for (int i = 0; i < ND; i++) begin
          if (an_lo[i]) begin
            buf_d[4*i +: 4] <= dec[3:0];
            buf_e[i]        <= dec[4];
            seen[i]         <= 1'b1;
          end
        end
      end

      unique case (1'b1)
        load: begin
          frame.frame_valid <= 1'b1;
          frame.digits      <= buf_d;
          frame.digit_err   <= buf_e;
          if (hs)
            overrun <= 1'b0;
        end
        drop: overrun <= 1'b1;
        hs && !full: begin
          frame.frame_valid <= 1'b0;
          overrun           <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sevenseg_reader.sv
// Directed and randomized checks of sevenseg_reader
// against a table-driven frame-level reference.
module tb_sevenseg_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  e;
  } frm_t;

  typedef logic [6:0] seg4_t [4];

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [6:0]   seg_n = 7'h7F;
  logic [ND-1:0] an_n = '1;
  logic         overrun;

  sevenseg_reader_if #(.NUM_DIGITS(ND)) bus ();

  sevenseg_reader #(
    .NUM_DIGITS(ND),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .seg_n(seg_n),
    .an_n(an_n),
    .frame(bus.master),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  frm_t q[$];

  logic [6:0] enc [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h18
  };

  // negedge sees exactly what the next posedge will use
  always @(negedge clk)
    if (reset_n && bus.frame_valid && bus.frame_ready)
      q.push_back({bus.digits, bus.digit_err});

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] ref_dec(
    input logic [6:0] s
  );
    logic [4:0] r;
    r = 5'h1E;
    if (s == 7'h7F) r = 5'h0F;
    for (int i = 0; i < 10; i++)
      if (enc[i] == s) r = {1'b0, 4'(i)};
    return r;
  endfunction

  function automatic frm_t exp_of(input seg4_t s);
    frm_t f;
    logic [4:0] r;
    for (int i = 0; i < 4; i++) begin
      r = ref_dec(s[i]);
      f.d[4*i +: 4] = r[3:0];
      f.e[i] = r[4];
    end
    return f;
  endfunction

  function automatic logic [6:0] rnd_seg();
    int r;
    r = $urandom_range(0, 11);
    if (r < 10) return enc[r];
    if (r == 10) return 7'h7F;
    return 7'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [3:0] a,
                      input logic [6:0] s,
                      input int n);
    an_n  = a;
    seg_n = s;
    repeat (n) tick();
  endtask

  task automatic show(input int idx,
                      input logic [6:0] s,
                      input int n);
    logic [3:0] a;
    a = 4'b0001 << idx;
    hold(~a, s, n);
  endtask

  task automatic idle(input int n);
    hold(4'hF, 7'h7F, n);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input string tag,
                              input frm_t f);
    int t;
    frm_t g;
    t = 0;
    while (q.size() == 0 && t < 40) begin
      tick();
      t++;
    end
    chk({tag, "_count"}, q.size(), 1);
    if (q.size() > 0) begin
      g = q.pop_front();
      chk({tag, "_digits"}, 32'(g.d), 32'(f.d));
      chk({tag, "_err"}, 32'(g.e), 32'(f.e));
    end
    q.delete();
  endtask

  initial begin
    int lat;
    seg4_t s;
    int ord [4];
    int j;
    int tmp;
    frm_t f;

    bus.frame_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.frame_valid), 0);
    chk("rst_digits", 32'(bus.digits), 0);
    chk("rst_err", 32'(bus.digit_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    reset_n = 1'b1;
    bus.frame_ready = 1'b1;
    idle(4);

    // basic frame and latency of the last digit
    show(0, 7'h40, 10);
    show(1, 7'h79, 10);
    show(2, 7'h24, 10);
    an_n  = 4'b0111;
    seg_n = 7'h30;
    lat = 0;
    while (!bus.frame_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk("latency", lat, 2 + SC - 1 + 1);
    repeat (4) tick();
    f.d = 16'h3210;
    f.e = 4'b0000;
    expect_frame("basic", f);
    idle(6);

    // invalid and blank patterns
    show(0, 7'h40, 10);
    show(1, 7'h7F, 10);
    show(2, 7'h55, 10);
    show(3, 7'h12, 10);
    f.d = 16'h5EF0;
    f.e = 4'b0100;
    expect_frame("errblank", f);
    idle(6);

    // glitching digit 0 must not be captured
    show(1, 7'h79, 10);
    show(2, 7'h24, 10);
    show(3, 7'h30, 10);
    an_n = 4'b1110;
    for (int k = 0; k < 10; k++) begin
      seg_n = (k % 2 != 0) ? 7'h79 : 7'h40;
      repeat (2) tick();
    end
    chk("glitch_nocap", q.size(), 0);
    seg_n = 7'h24;
    repeat (10) tick();
    f.d = 16'h3212;
    f.e = 4'b0000;
    expect_frame("glitch", f);
    idle(6);

    // two anodes low: ignored
    show(0, 7'h19, 10);
    show(1, 7'h02, 10);
    hold(4'b1100, 7'h00, 20);
    chk("multi_noframe", q.size(), 0);
    chk("multi_valid", 32'(bus.frame_valid), 0);
    show(2, 7'h78, 10);
    show(3, 7'h18, 10);
    f.d = 16'h9764;
    f.e = 4'b0000;
    expect_frame("multi", f);
    idle(6);

    // backpressure and overrun
    bus.frame_ready = 1'b0;
    show(0, 7'h79, 10);
    show(1, 7'h24, 10);
    show(2, 7'h30, 10);
    show(3, 7'h19, 10);
    chk("bp_valid1", 32'(bus.frame_valid), 1);
    chk("bp_digits1", 32'(bus.digits), 32'h4321);
    chk("bp_ovr1", 32'(overrun), 0);
    idle(4);
    show(0, 7'h12, 10);
    show(1, 7'h02, 10);
    show(2, 7'h78, 10);
    show(3, 7'h00, 10);
    chk("bp_valid2", 32'(bus.frame_valid), 1);
    chk("bp_digits2", 32'(bus.digits), 32'h4321);
    chk("bp_ovr2", 32'(overrun), 1);
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    chk("hs_valid", 32'(bus.frame_valid), 0);
    chk("hs_ovr", 32'(overrun), 0);
    f.d = 16'h4321;
    f.e = 4'b0000;
    expect_frame("bp_first", f);
    bus.frame_ready = 1'b1;
    idle(6);

    // reset mid-frame discards partial captures
    show(0, 7'h40, 10);
    show(1, 7'h79, 10);
    show(2, 7'h24, 10);
    idle(2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mrst_valid", 32'(bus.frame_valid), 0);
    chk("mrst_digits", 32'(bus.digits), 0);
    show(3, 7'h30, 20);
    chk("mrst_noframe", q.size(), 0);
    chk("mrst_nvalid", 32'(bus.frame_valid), 0);
    show(0, 7'h24, 10);
    show(1, 7'h30, 10);
    show(2, 7'h40, 10);
    f.d = 16'h3032;
    f.e = 4'b0000;
    expect_frame("mrst", f);
    idle(6);

    // randomized frames, random order, optional rewrite
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 4; i++) begin
        s[i] = rnd_seg();
        ord[i] = i;
      end
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = ord[i];
        ord[i] = ord[j];
        ord[j] = tmp;
      end
      for (int i = 0; i < 3; i++)
        show(ord[i], s[ord[i]], 8);
      if ($urandom_range(0, 1) == 1) begin
        s[ord[0]] = rnd_seg();
        show(ord[0], s[ord[0]], 8);
      end
      show(ord[3], s[ord[3]], 10);
      expect_frame($sformatf("rand%0d", n), exp_of(s));
      idle(4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
